// File: rtl/layer_output_serializer.sv
// ============================================================================
// Module   : layer_output_serializer
// Brief    : Captures a full layer of neuron outputs and replays them one word
//            per cycle, with a one-deep pending frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_output_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    input  logic                              err_clear,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_out_valid,
    output logic                              busy,
    output logic                              err_overrun,
    output logic                              err_partial
);

    localparam int          c_cw    = $clog2(NUM_NEURONS + 1);
    localparam int          c_fw    = NUM_NEURONS * DATA_WIDTH;
    localparam logic [c_cw-1:0] c_last = c_cw'(NUM_NEURONS);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [c_cw-1:0]                r_count;
    logic [DATA_WIDTH-1:0]          r_data;
    logic [c_fw-DATA_WIDTH-1:0]     r_shreg;
    logic [c_fw-1:0]                r_pend_frame;
    logic                           r_pend;
    logic                           r_err_overrun;
    logic                           r_err_partial;

    logic w_capture;
    logic w_partial;
    logic w_load_new;
    logic w_load_pend;
    logic w_advance;
    logic w_store_pend;
    logic w_drop;

    always_comb begin
        w_capture    = &neuron_valid;
        w_partial    = (|neuron_valid) & ~w_capture;
        w_state_nxt  = r_state;
        w_load_new   = 1'b0;
        w_load_pend  = 1'b0;
        w_advance    = 1'b0;
        w_store_pend = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_load_new  = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (r_count == c_last) begin
                    // Final word already on the output: chain the next frame with no bubble.
                    if (r_pend) begin
                        w_load_pend  = 1'b1;
                        w_store_pend = w_capture;
                    end else if (w_capture) begin
                        w_load_new = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_advance = 1'b1;
                    if (w_capture) begin
                        w_drop       = r_pend;
                        w_store_pend = ~r_pend;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_data        <= '0;
            r_pend        <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_new) begin
                r_data  <= neuron_out[DATA_WIDTH-1:0];
                r_count <= c_one;
            end else if (w_load_pend) begin
                r_data  <= r_pend_frame[DATA_WIDTH-1:0];
                r_count <= c_one;
            end else if (w_advance) begin
                r_data  <= r_shreg[DATA_WIDTH-1:0];
                r_count <= r_count + c_one;
            end
            if (w_store_pend) begin
                r_pend <= 1'b1;
            end else if (w_load_pend) begin
                r_pend <= 1'b0;
            end
            // A new error in the same cycle as err_clear keeps the flag set.
            r_err_overrun <= w_drop | (r_err_overrun & ~err_clear);
            r_err_partial <= w_partial | (r_err_partial & ~err_clear);
        end
    end

    // Frame storage carries no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_load_new) begin
            r_shreg <= neuron_out[c_fw-1:DATA_WIDTH];
        end else if (w_load_pend) begin
            r_shreg <= r_pend_frame[c_fw-1:DATA_WIDTH];
        end else if (w_advance) begin
            r_shreg <= r_shreg >> DATA_WIDTH;
        end
        if (w_store_pend) begin
            r_pend_frame <= neuron_out;
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = (r_state == S_SEND);
    assign busy           = (r_state == S_SEND) | r_pend;
    assign err_overrun    = r_err_overrun;
    assign err_partial    = r_err_partial;

endmodule

`default_nettype wire
